ga_mutation_sched: RTL and testbench

Scheduler that shares the single mutation datapath (`ga_mutation_algo`) between `N_REQ` crossover engines. It sits between the crossover engines and the chromosome queue. Per accepted child it:
- arbitrates round-robin between the engines;
- decides, from the mutation-rate counter, whether the child is pushed mutated or unchanged;
- pushes the result into the chromosome queue, respecting `queue_full` backpressure.

---
 rtl/ga_pkg.sv | 30 +++
 rtl/ga_rr_arbiter.sv | 36 +++
 rtl/ga_mutation_sched.sv | 164 ++++++++++++++++
 tb/tb_ga_mutation_sched.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ga_pkg.sv
// ga_pkg: shared definitions for the GA mutation scheduler slice.
//   - ga_state_e   : scheduler FSM states (IDLE / GRANT / XFER)
//   - MUT_RATE_MIN : smallest legal "one child in N" mutation rate
//   - MUT_RATE_MAX : largest legal mutation rate
//   - CHROM_MAX_W  : default chromosome width
//   - clamp_rate() : folds any programmed rate into [MUT_RATE_MIN, MUT_RATE_MAX]
package ga_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2
    } ga_state_e;

    localparam int unsigned MUT_RATE_MIN = 2;
    localparam int unsigned MUT_RATE_MAX = 10;
    localparam int unsigned CHROM_MAX_W  = 32;

    // Result always fits in 4 bits because MUT_RATE_MAX is 10.
    function automatic logic [3:0] clamp_rate(input logic [31:0] rate);
        if (rate < MUT_RATE_MIN) begin
            return 4'(MUT_RATE_MIN);
        end
        if (rate > MUT_RATE_MAX) begin
            return 4'(MUT_RATE_MAX);
        end
        return rate[3:0];
    endfunction

endpackage

// File: rtl/ga_rr_arbiter.sv
// ga_rr_arbiter: combinational round-robin arbiter.
// Grants the first requesting index strictly after ptr, wrapping at N_REQ-1.
// The pointer register is owned by the parent.
// Ports:
//   req   in  N_REQ           request vector
//   ptr   in  $clog2(N_REQ)   index of the most recent winner
//   grant out N_REQ           one-hot grant (all zero when no request)
module ga_rr_arbiter #(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant
);
    import ga_pkg::*;

    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            // Explicit wrap: N_REQ need not be a power of two.
            idx = (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + IDX_W'(1);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ga_mutation_sched.sv
// ga_mutation_sched: shares one mutation datapath between N_REQ crossover engines.
// Per child: round-robin grant, capture into a hold register, then push either
// the mutated or the unchanged chromosome into the queue, honouring queue_full.
// Ports:
//   clk, rst (async, active high), sw_rst (sync, same effect as rst)
//   mutation_rate_max_cntr  one child in N mutated, clamped to 2..10
//   req_valid / req_child   per-requester valid and flat child vector
//   req_ack                 registered one-hot acknowledge pulse
//   mut_child / mut_result  held child to the datapath / its combinational result
//   queue_full / queue_push / queue_chromosome / mut_applied   queue push side
//   busy                    FSM is not idle
//   stat_push_cnt / stat_mut_cnt   saturating statistics
// Configuration: define GA_MUT_SCHED_STATS_EN to build the statistics counters;
// otherwise both stats ports are tied to zero.
module ga_mutation_sched #(
    parameter int unsigned N_REQ       = 2,
    parameter int unsigned CHROM_MAX_W = 32,
    parameter int unsigned RATE_W      = 4,
    parameter int unsigned STAT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sw_rst,
    input  logic [RATE_W-1:0]            mutation_rate_max_cntr,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*CHROM_MAX_W-1:0] req_child,
    output logic [N_REQ-1:0]             req_ack,
    output logic [CHROM_MAX_W-1:0]       mut_child,
    input  logic [CHROM_MAX_W-1:0]       mut_result,
    input  logic                         queue_full,
    output logic                         queue_push,
    output logic [CHROM_MAX_W-1:0]       queue_chromosome,
    output logic                         mut_applied,
    output logic                         busy,
    output logic [STAT_W-1:0]            stat_push_cnt,
    output logic [STAT_W-1:0]            stat_mut_cnt
);
    import ga_pkg::*;

    localparam int unsigned IDX_W = $clog2(N_REQ);

    ga_state_e              state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, win_idx;
    logic [3:0]             cnt_q, rate_max;
    logic [N_REQ-1:0]       grant, ack_q;
    logic [CHROM_MAX_W-1:0] hold_q, chrom_q, win_child;
    logic                   push_q, applied_q;
    logic                   accept, push_now, sel;

    ga_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant)
    );

    assign rate_max = clamp_rate(32'(mutation_rate_max_cntr));
    // cnt_q may exceed max-1 after max is lowered; >= forces a mutation then.
    assign sel      = (cnt_q >= (rate_max - 4'd1));

    always_comb begin
        win_child = '0;
        win_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                win_child = win_child | req_child[i*CHROM_MAX_W +: CHROM_MAX_W];
                win_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        push_now = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    accept  = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: state_d = XFER;
            XFER: begin
                if (!queue_full) begin
                    push_now = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= IDX_W'(N_REQ - 1);
            cnt_q     <= '0;
            ack_q     <= '0;
            hold_q    <= '0;
            chrom_q   <= '0;
            push_q    <= 1'b0;
            applied_q <= 1'b0;
        end else if (sw_rst) begin
            state_q   <= IDLE;
            ptr_q     <= IDX_W'(N_REQ - 1);
            cnt_q     <= '0;
            ack_q     <= '0;
            hold_q    <= '0;
            chrom_q   <= '0;
            push_q    <= 1'b0;
            applied_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_q     <= accept ? grant : '0;
            push_q    <= push_now;
            applied_q <= push_now & sel;
            if (accept) begin
                hold_q <= win_child;
                ptr_q  <= win_idx;
            end
            if (push_now) begin
                chrom_q <= sel ? mut_result : hold_q;
                cnt_q   <= sel ? '0 : cnt_q + 4'd1;
            end
        end
    end

    assign req_ack          = ack_q;
    assign mut_child        = hold_q;
    assign queue_push       = push_q;
    assign queue_chromosome = chrom_q;
    assign mut_applied      = applied_q;
    assign busy             = (state_q != IDLE);

`ifdef GA_MUT_SCHED_STATS_EN
    logic [STAT_W-1:0] push_cnt_q, mut_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            push_cnt_q <= '0;
            mut_cnt_q  <= '0;
        end else if (sw_rst) begin
            push_cnt_q <= '0;
            mut_cnt_q  <= '0;
        end else begin
            if (push_q && (push_cnt_q != '1)) begin
                push_cnt_q <= push_cnt_q + STAT_W'(1);
            end
            if (push_q && applied_q && (mut_cnt_q != '1)) begin
                mut_cnt_q <= mut_cnt_q + STAT_W'(1);
            end
        end
    end

    assign stat_push_cnt = push_cnt_q;
    assign stat_mut_cnt  = mut_cnt_q;
`else
    assign stat_push_cnt = '0;
    assign stat_mut_cnt  = '0;
`endif

endmodule

// File: tb/tb_ga_mutation_sched.sv
// Self-checking bench for ga_mutation_sched: directed scenarios plus randomized
// rounds, checked against a transaction-level model of arbitration and mutation rate.
module tb_ga_mutation_sched;
    localparam int unsigned N_REQ  = 3;
    localparam int unsigned W      = 32;
    localparam int unsigned RATE_W = 4;
    localparam int unsigned STAT_W = 4;
    localparam logic [W-1:0] MUT_MASK = 32'hA5C3_3C5A;

    logic                 clk = 1'b0;
    logic                 rst, sw_rst, queue_full;
    logic [RATE_W-1:0]    rate;
    logic [N_REQ-1:0]     req_valid, req_ack;
    logic [N_REQ*W-1:0]   req_child;
    logic [W-1:0]         mut_child, mut_result, queue_chromosome;
    logic                 queue_push, mut_applied, busy;
    logic [STAT_W-1:0]    stat_push_cnt, stat_mut_cnt;

    always #5 clk = ~clk;

    // Stand-in mutation datapath: any invertible transform of the held child.
    assign mut_result = mut_child ^ MUT_MASK;

    ga_mutation_sched #(
        .N_REQ       (N_REQ),
        .CHROM_MAX_W (W),
        .RATE_W      (RATE_W),
        .STAT_W      (STAT_W)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .sw_rst                 (sw_rst),
        .mutation_rate_max_cntr (rate),
        .req_valid              (req_valid),
        .req_child              (req_child),
        .req_ack                (req_ack),
        .mut_child              (mut_child),
        .mut_result             (mut_result),
        .queue_full             (queue_full),
        .queue_push             (queue_push),
        .queue_chromosome       (queue_chromosome),
        .mut_applied            (mut_applied),
        .busy                   (busy),
        .stat_push_cnt          (stat_push_cnt),
        .stat_mut_cnt           (stat_mut_cnt)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state: last winner, children since last mutation, stats.
    int       m_ptr, m_cnt, m_push, m_mut;
    bit       pend [N_REQ];
    logic [W-1:0] pend_child [N_REQ];
    int       mut_seen;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int clamp_m(input int r);
        if (r < 2) return 2;
        if (r > 10) return 10;
        return r;
    endfunction

    function automatic int rr_pick();
        for (int k = 1; k <= N_REQ; k++) begin
            if (pend[(m_ptr + k) % N_REQ]) return (m_ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr  = N_REQ - 1;
        m_cnt  = 0;
        m_push = 0;
        m_mut  = 0;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N_REQ; i++) begin
            req_valid[i]          = pend[i];
            req_child[i*W +: W]   = pend_child[i];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N_REQ; i++) pend[i] = 1'b0;
        drive_reqs();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Raise requesters in 'want' (keeping any child already pending), drop the rest.
    task automatic offer(input logic [N_REQ-1:0] want);
        for (int i = 0; i < N_REQ; i++) begin
            if (want[i] && !pend[i]) begin
                pend[i]       = 1'b1;
                pend_child[i] = $urandom;
            end else if (!want[i]) begin
                pend[i] = 1'b0;
            end
        end
        drive_reqs();
    endtask

    // One full child transfer. Called at a negedge with the DUT idle.
    task automatic run_child(input logic [N_REQ-1:0] want, input int stall);
        int               win, lat, mx;
        logic [N_REQ-1:0] exp_ack;
        logic [W-1:0]     child, exp_chrom;
        bit               exp_mut;
        offer(want);
        win = rr_pick();
        if (win < 0) return;
        child   = pend_child[win];
        exp_ack = '0;
        exp_ack[win] = 1'b1;

        @(negedge clk);
        check_eq("ack_onehot", req_ack, exp_ack);
        check_eq("held_child", mut_child, child);
        check_eq("busy_grant", busy, 1);
        check_eq("push_single_pulse", queue_push, 0);
        pend[win] = 1'b0;
        drive_reqs();

        @(negedge clk);
        check_eq("ack_pulse_len", req_ack, 0);
        check_eq("xfer_no_early_push", queue_push, 0);
        queue_full = (stall > 0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check_eq("stall_no_push", queue_push, 0);
        end
        queue_full = 1'b0;

        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!queue_push && lat < 8);
        check_eq("push_latency", lat, 1);

        mx        = clamp_m(int'(rate));
        exp_mut   = (m_cnt + 1 >= mx);
        exp_chrom = exp_mut ? (child ^ MUT_MASK) : child;
        m_cnt     = exp_mut ? 0 : m_cnt + 1;
        m_ptr     = win;
        if (m_push < (1 << STAT_W) - 1) m_push++;
        if (exp_mut && m_mut < (1 << STAT_W) - 1) m_mut++;

        check_eq("push_chromosome", queue_chromosome, exp_chrom);
        check_eq("mut_applied", mut_applied, exp_mut);
        check_eq("busy_after_push", busy, 0);
        if (mut_applied) mut_seen++;
    endtask

    task automatic check_stats(input string tag);
        @(negedge clk);
`ifdef GA_MUT_SCHED_STATS_EN
        check_eq({tag, "_push_cnt"}, stat_push_cnt, m_push);
        check_eq({tag, "_mut_cnt"}, stat_mut_cnt, m_mut);
`else
        check_eq({tag, "_push_cnt"}, stat_push_cnt, 0);
        check_eq({tag, "_mut_cnt"}, stat_mut_cnt, 0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        sw_rst     = 1'b0;
        queue_full = 1'b0;
        rate       = 4'd3;
        req_valid  = '0;
        req_child  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pend[i]       = 1'b0;
            pend_child[i] = '0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("rst_ack", req_ack, 0);
        check_eq("rst_mut_child", mut_child, 0);
        check_eq("rst_push", queue_push, 0);
        check_eq("rst_chrom", queue_chromosome, 0);
        check_eq("rst_applied", mut_applied, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_stat_push", stat_push_cnt, 0);
        check_eq("rst_stat_mut", stat_mut_cnt, 0);
        rst = 1'b0;

        // Single requester, one in three mutated.
        rate     = 4'd3;
        mut_seen = 0;
        for (int n = 0; n < 6; n++) run_child(3'b001, 0);
        check_eq("rate3_mut_count", mut_seen, 2);

        // Two engines continuously valid: strict alternation.
        do_reset();
        rate = 4'd10;
        for (int n = 0; n < 4; n++) run_child(3'b011, 0);

        // Five-cycle backpressure in XFER.
        run_child(3'b100, 5);
        run_child(3'b010, 5);

        // Lowering max below the counter forces a mutation.
        do_reset();
        rate = 4'd10;
        for (int n = 0; n < 7; n++) run_child(3'b001, 0);
        rate = 4'd2;
        run_child(3'b001, 0);
        check_eq("dec_max_forces_mut", mut_applied, 1);
        run_child(3'b001, 0);
        check_eq("dec_max_cnt_cleared", mut_applied, 0);
        rate = 4'd0;
        run_child(3'b001, 0);
        run_child(3'b001, 0);
        rate = 4'd15;
        for (int n = 0; n < 11; n++) run_child(3'b010, 0);

        // Asynchronous reset while a child is in XFER.
        offer(3'b001);
        @(negedge clk);
        check_eq("rstx_ack", req_ack, 3'b001);
        pend[0] = 1'b0;
        drive_reqs();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("rstx_busy", busy, 0);
        check_eq("rstx_mut_child", mut_child, 0);
        check_eq("rstx_push", queue_push, 0);
        check_eq("rstx_chrom", queue_chromosome, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check_eq("rstx_no_push", queue_push, 0);
        end
        run_child(3'b011, 0);

        // Soft reset during GRANT.
        offer(3'b100);
        @(negedge clk);
        pend[2] = 1'b0;
        drive_reqs();
        sw_rst = 1'b1;
        @(negedge clk);
        sw_rst = 1'b0;
        model_reset();
        check_eq("swrst_busy", busy, 0);
        check_eq("swrst_ack", req_ack, 0);
        check_eq("swrst_mut_child", mut_child, 0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check_eq("swrst_no_push", queue_push, 0);
        end
        run_child(3'b111, 0);

        // Randomized rounds.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) rate = RATE_W'($urandom_range(0, 15));
            run_child(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        end
        check_stats("random");

        // Saturating statistics.
        do_reset();
        rate = 4'd2;
        for (int n = 0; n < 20; n++) run_child(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)), 0);
        check_stats("sat");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
